// File: rtl/extmem_arb_if.sv
// rtl/extmem_arb_if.sv - requester and RAM port bundle for the external memory arbiter
interface extmem_arb_if;
    logic        p0_req;
    logic [16:0] p0_addr;
    logic [17:0] p0_wdata;
    logic [1:0]  p0_wena;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [17:0] p0_rdata;

    logic        p1_req;
    logic [16:0] p1_addr;
    logic [17:0] p1_wdata;
    logic [1:0]  p1_wena;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [17:0] p1_rdata;

    logic [16:0] extmemaddr;
    logic [17:0] extmemdout;
    logic [17:0] extmemdin;
    logic        extmemenab;
    logic [1:0]  extmemwena;
    logic [3:0]  p1_starved;

    // Arbiter side
    modport slave (
        input  p0_req, p0_addr, p0_wdata, p0_wena,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_addr, p1_wdata, p1_wena,
        output p1_gnt, p1_rvalid, p1_rdata,
        output extmemaddr, extmemdout, extmemenab, extmemwena,
        input  extmemdin,
        output p1_starved
    );

    // Requester / RAM side
    modport master (
        output p0_req, p0_addr, p0_wdata, p0_wena,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_addr, p1_wdata, p1_wena,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  extmemaddr, extmemdout, extmemenab, extmemwena,
        output extmemdin,
        input  p1_starved
    );
endinterface

// File: rtl/extmem_arb.sv
// rtl/extmem_arb.sv - two-port priority arbiter and sequencer for the external block RAM
module extmem_arb #(
    parameter int LATENCY = 3,
    parameter int STARVE  = 4
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    extmem_arb_if.slave  bus
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_L = 4'(STARVE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] stc;
    logic       own;
    logic       p0_win;
    logic       p1_win;
    logic       done;

    assign bus.p1_starved = stc;

    // State register
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Arbitration and sequencing decisions; port 1 only beats port 0 once starved
    always_comb begin
        state_nxt = state;
        p0_win    = 1'b0;
        p1_win    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                p1_win = bus.p1_req & (~bus.p0_req | (stc == STARVE_L));
                p0_win = bus.p0_req & ~p1_win;
                if (p0_win | p1_win) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // RAM port, grant/completion pulses and read capture; extmemwena doubles as the read/write flag
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            cnt            <= '0;
            own            <= 1'b0;
            bus.extmemaddr <= '0;
            bus.extmemdout <= '0;
            bus.extmemenab <= 1'b0;
            bus.extmemwena <= '0;
            bus.p0_gnt     <= 1'b0;
            bus.p1_gnt     <= 1'b0;
            bus.p0_rvalid  <= 1'b0;
            bus.p1_rvalid  <= 1'b0;
            bus.p0_rdata   <= '0;
            bus.p1_rdata   <= '0;
        end else begin
            bus.p0_gnt    <= 1'b0;
            bus.p1_gnt    <= 1'b0;
            bus.p0_rvalid <= 1'b0;
            bus.p1_rvalid <= 1'b0;
            if (p0_win | p1_win) begin
                bus.extmemaddr <= p1_win ? bus.p1_addr  : bus.p0_addr;
                bus.extmemdout <= p1_win ? bus.p1_wdata : bus.p0_wdata;
                bus.extmemwena <= p1_win ? bus.p1_wena  : bus.p0_wena;
                bus.extmemenab <= 1'b1;
                bus.p0_gnt     <= p0_win;
                bus.p1_gnt     <= p1_win;
                own            <= p1_win;
                cnt            <= LAT_M1;
            end else if (state == IDLE) begin
                bus.extmemenab <= 1'b0;
                bus.extmemwena <= '0;
            end else if (!done) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                if (bus.extmemwena == 2'b00) begin
                    if (own) bus.p1_rdata <= bus.extmemdin;
                    else     bus.p0_rdata <= bus.extmemdin;
                end
                bus.p0_rvalid  <= ~own;
                bus.p1_rvalid  <= own;
                bus.extmemenab <= 1'b0;
                bus.extmemwena <= '0;
            end
        end
    end

    // Starvation count: grows on port 0 grants while port 1 waits, cleared when port 1 is served or idle
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            stc <= '0;
        end else if (state == IDLE) begin
            if (!bus.p1_req || p1_win)          stc <= '0;
            else if (p0_win && stc != STARVE_L) stc <= stc + 4'd1;
        end
    end

endmodule

// File: tb/tb_extmem_arb.sv
// tb/tb_extmem_arb.sv - directed self-checking bench for extmem_arb
module tb_extmem_arb;
    localparam int LAT = 3;

    logic CLOCK = 1'b0;
    logic RESET_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    extmem_arb_if bus ();

    extmem_arb #(.LATENCY(LAT), .STARVE(4)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    // RAM model: data valid only on the final enable cycle, writes land on that cycle
    logic [17:0] mem [0:131071];
    int          en_cnt = 0;
    logic        pre_we = 1'b0;
    logic [16:0] pre_addr = '0;
    logic [17:0] pre_data = '0;

    assign bus.extmemdin = (bus.extmemenab && en_cnt == LAT - 1) ? mem[bus.extmemaddr] : 18'h15555;

    always @(posedge CLOCK) begin
        en_cnt <= bus.extmemenab ? en_cnt + 1 : 0;
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.extmemenab && en_cnt == LAT - 1) begin
            if (bus.extmemwena[0]) mem[bus.extmemaddr][8:0]  <= bus.extmemdout[8:0];
            if (bus.extmemwena[1]) mem[bus.extmemaddr][17:9] <= bus.extmemdout[17:9];
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [16:0] a, input logic [17:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        bus.p0_req = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wena = '0;
        bus.p1_req = 0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wena = '0;
        @(negedge CLOCK);
        preload(17'h01234, 18'h2A5A5);
        preload(17'h1FFFF, 18'h12345);
        preload(17'h00010, 18'h00111);
        preload(17'h00020, 18'h00222);

        // Reset state
        chk("rst_enab", 32'(bus.extmemenab), 32'h0);
        chk("rst_wena", 32'(bus.extmemwena), 32'h0);
        chk("rst_addr", 32'(bus.extmemaddr), 32'h0);
        chk("rst_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'h0);
        chk("rst_rdata0", 32'(bus.p0_rdata), 32'h0);
        chk("rst_starved", 32'(bus.p1_starved), 32'h0);
        RESET_N = 1'b1;
        tick();

        // Single read on port 0
        bus.p0_req = 1; bus.p0_addr = 17'h01234; bus.p0_wena = 2'b00;
        tick();
        chk("rd_gnt", 32'(bus.p0_gnt), 32'h1);
        chk("rd_enab1", 32'(bus.extmemenab), 32'h1);
        chk("rd_addr", 32'(bus.extmemaddr), 32'h01234);
        bus.p0_req = 0;
        tick();
        chk("rd_gnt_clr", 32'(bus.p0_gnt), 32'h0);
        chk("rd_enab2", 32'(bus.extmemenab), 32'h1);
        tick();
        chk("rd_enab3", 32'(bus.extmemenab), 32'h1);
        chk("rd_rvalid_early", 32'(bus.p0_rvalid), 32'h0);
        tick();
        chk("rd_rvalid", 32'(bus.p0_rvalid), 32'h1);
        chk("rd_enab_off", 32'(bus.extmemenab), 32'h0);
        chk("rd_rdata", 32'(bus.p0_rdata), 32'h2A5A5);
        tick();
        chk("rd_rvalid_clr", 32'(bus.p0_rvalid), 32'h0);

        // Byte write on port 1, then readback
        bus.p1_req = 1; bus.p1_addr = 17'h1FFFF; bus.p1_wdata = 18'h3FFFF; bus.p1_wena = 2'b01;
        tick();
        chk("wr_gnt", 32'(bus.p1_gnt), 32'h1);
        chk("wr_dout", 32'(bus.extmemdout), 32'h3FFFF);
        chk("wr_wena1", 32'(bus.extmemwena), 32'h1);
        bus.p1_req = 0; bus.p1_wena = 2'b00;
        tick();
        chk("wr_wena2", 32'(bus.extmemwena), 32'h1);
        tick();
        chk("wr_wena3", 32'(bus.extmemwena), 32'h1);
        tick();
        chk("wr_rvalid", 32'(bus.p1_rvalid), 32'h1);
        chk("wr_rdata_keep", 32'(bus.p1_rdata), 32'h0);
        chk("wr_wena_off", 32'(bus.extmemwena), 32'h0);
        bus.p1_req = 1;
        tick();
        chk("rb_gnt", 32'(bus.p1_gnt), 32'h1);
        bus.p1_req = 0;
        tick(); tick(); tick();
        chk("rb_rvalid", 32'(bus.p1_rvalid), 32'h1);
        chk("rb_rdata", 32'(bus.p1_rdata), 32'h123FF);
        tick();

        // Simultaneous single requests
        bus.p0_req = 1; bus.p0_addr = 17'h00010;
        bus.p1_req = 1; bus.p1_addr = 17'h00020;
        tick();
        chk("sim_p0_gnt", 32'(bus.p0_gnt), 32'h1);
        chk("sim_p1_nogt", 32'(bus.p1_gnt), 32'h0);
        chk("sim_stc1", 32'(bus.p1_starved), 32'h1);
        bus.p0_req = 0;
        tick(); tick(); tick();
        chk("sim_p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
        chk("sim_p0_rdata", 32'(bus.p0_rdata), 32'h00111);
        chk("sim_p1_wait", 32'(bus.p1_gnt), 32'h0);
        tick();
        chk("sim_p1_gnt", 32'(bus.p1_gnt), 32'h1);
        chk("sim_stc0", 32'(bus.p1_starved), 32'h0);
        bus.p1_req = 0;
        tick(); tick(); tick();
        chk("sim_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
        chk("sim_p1_rdata", 32'(bus.p1_rdata), 32'h00222);
        tick();

        // Starvation: both held, expect p0 x4 then p1, one grant every 4 cycles
        bus.p0_req = 1; bus.p1_req = 1;
        tick();
        for (int g = 0; g < 10; g++) begin
            chk($sformatf("stv_p0_gnt%0d", g), 32'(bus.p0_gnt), (g % 5 == 4) ? 32'h0 : 32'h1);
            chk($sformatf("stv_p1_gnt%0d", g), 32'(bus.p1_gnt), (g % 5 == 4) ? 32'h1 : 32'h0);
            chk($sformatf("stv_stc%0d", g), 32'(bus.p1_starved), (g % 5 == 4) ? 32'h0 : 32'(g % 5 + 1));
            if (g == 9) begin
                bus.p0_req = 0; bus.p1_req = 0;
            end
            tick(); tick(); tick(); tick();
        end
        chk("stv_idle", 32'(bus.extmemenab), 32'h0);

        // Reset in the middle of an access
        bus.p0_req = 1; bus.p0_addr = 17'h01234;
        tick();
        bus.p0_req = 0;
        tick();
        chk("mr_enab2", 32'(bus.extmemenab), 32'h1);
        RESET_N = 1'b0;
        tick();
        chk("mr_enab", 32'(bus.extmemenab), 32'h0);
        chk("mr_addr", 32'(bus.extmemaddr), 32'h0);
        chk("mr_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
        chk("mr_rdata0", 32'(bus.p0_rdata), 32'h0);
        chk("mr_rdata1", 32'(bus.p1_rdata), 32'h0);
        RESET_N = 1'b1;
        tick();
        chk("mr_no_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
        tick();
        chk("mr_no_rvalid2", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
        bus.p1_req = 1; bus.p1_addr = 17'h01234; bus.p1_wena = 2'b00;
        tick();
        chk("mr_p1_gnt", 32'(bus.p1_gnt), 32'h1);
        bus.p1_req = 0;
        tick(); tick(); tick();
        chk("mr_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
        chk("mr_p1_rdata", 32'(bus.p1_rdata), 32'h2A5A5);
        tick();

        // Held request with address changed at grant
        bus.p0_req = 1; bus.p0_addr = 17'h00010;
        tick();
        chk("hd_gnt1", 32'(bus.p0_gnt), 32'h1);
        bus.p0_addr = 17'h00020;
        tick(); tick(); tick();
        chk("hd_rvalid1", 32'(bus.p0_rvalid), 32'h1);
        chk("hd_rdata1", 32'(bus.p0_rdata), 32'h00111);
        chk("hd_gap", 32'(bus.extmemenab), 32'h0);
        tick();
        chk("hd_gnt2", 32'(bus.p0_gnt), 32'h1);
        chk("hd_addr2", 32'(bus.extmemaddr), 32'h00020);
        bus.p0_req = 0;
        tick(); tick(); tick();
        chk("hd_rvalid2", 32'(bus.p0_rvalid), 32'h1);
        chk("hd_rdata2", 32'(bus.p0_rdata), 32'h00222);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
